// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction field positions, sequencer states
// and default widths used by the fetch/decode controller and its bus interface.
package cpu_pkg;

    localparam int INSTR_WIDTH_DEF = 16;
    localparam int PC_WIDTH_DEF    = 4;

    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 12;
    localparam int ADDR_A_MSB = 11;
    localparam int ADDR_A_LSB = 8;
    localparam int ADDR_B_MSB = 7;
    localparam int ADDR_B_LSB = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_DIV  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MC_WAIT,
        WRITEBACK,
        ADVANCE,
        HALTED
    } state_t;

    function automatic logic is_single_cycle(input logic [3:0] opc);
        return opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

    function automatic logic is_multi_cycle(input logic [3:0] opc);
        return opc inside {OP_MUL, OP_DIV};
    endfunction

endpackage

// File: rtl/fetch_decode_controller_if.sv
// Controller-side bus: instruction memory read port, ALU handshake and
// register-file read/write addressing.
interface fetch_decode_controller_if
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) ();

    logic [PC_WIDTH-1:0]    program_counter;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [3:0]             rd_addr_a;
    logic [3:0]             rd_addr_b;
    logic [3:0]             alu_op;
    logic                   alu_start;
    logic                   alu_done;
    logic                   alu_div_zero;
    logic                   wb_en;
    logic [3:0]             wb_addr;

    modport master (
        output program_counter, rd_addr_a, rd_addr_b, alu_op, alu_start, wb_en, wb_addr,
        input  instruction, alu_done, alu_div_zero
    );

    modport slave (
        input  program_counter, rd_addr_a, rd_addr_b, alu_op, alu_start, wb_en, wb_addr,
        output instruction, alu_done, alu_div_zero
    );

endinterface

// File: rtl/mc_timeout_counter.sv
// Counts cycles spent waiting on a multi-cycle ALU op; expired marks the last
// permitted wait cycle so the sequencer can flag a hang.
module mc_timeout_counter #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    logic [CW-1:0] count;

    // Saturates at the limit so a late clear can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(MC_TIMEOUT - 1));

endmodule

// File: rtl/fetch_decode_controller.sv
// Fetch/decode sequencer: owns PC, instruction register and halt/error status,
// and steps each instruction through decode, ALU, multi-cycle wait and writeback.
module fetch_decode_controller
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int MC_TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    fetch_decode_controller_if.master bus,
    output logic [INSTR_WIDTH-1:0]    instr_reg,
    output logic                      halted,
    output logic                      error,
    output logic                      div_zero_flag
);

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          opcode;
    logic                mc_expired;
    logic                load_ir;
    logic                advance_pc;
    logic                set_halt;
    logic                set_error;
    logic                set_div_zero;
    logic                start_req;
    logic                wb_req;

    assign opcode = instr_reg[OPC_MSB:OPC_LSB];

    mc_timeout_counter #(
        .MC_TIMEOUT (MC_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (state != MC_WAIT),
        .count_en (state == MC_WAIT),
        .expired  (mc_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            pc            <= '0;
            instr_reg     <= '0;
            halted        <= 1'b0;
            error         <= 1'b0;
            div_zero_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (load_ir)      instr_reg     <= bus.instruction;
            if (advance_pc)   pc            <= pc + 1'b1;
            if (set_halt)     halted        <= 1'b1;
            if (set_error)    error         <= 1'b1;
            if (set_div_zero) div_zero_flag <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        load_ir      = 1'b0;
        advance_pc   = 1'b0;
        set_halt     = 1'b0;
        set_error    = 1'b0;
        set_div_zero = 1'b0;
        start_req    = 1'b0;
        wb_req       = 1'b0;
        case (state)
            FETCH: begin
                if (enable) begin
                    load_ir    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OP_HALT) begin
                    set_halt   = 1'b1;
                    state_next = HALTED;
                end else if (is_multi_cycle(opcode)) begin
                    start_req  = 1'b1;
                    state_next = MC_WAIT;
                end else if (is_single_cycle(opcode)) begin
                    state_next = EXECUTE;
                end else begin
                    state_next = ADVANCE;
                end
            end
            EXECUTE: state_next = WRITEBACK;
            // A completion arriving on the final wait cycle beats the timeout.
            MC_WAIT: begin
                if (bus.alu_done) begin
                    if (opcode == OP_DIV && bus.alu_div_zero) begin
                        set_div_zero = 1'b1;
                        state_next   = ADVANCE;
                    end else begin
                        state_next = WRITEBACK;
                    end
                end else if (mc_expired) begin
                    set_error  = 1'b1;
                    set_halt   = 1'b1;
                    state_next = HALTED;
                end
            end
            WRITEBACK: begin
                wb_req     = 1'b1;
                state_next = ADVANCE;
            end
            ADVANCE: begin
                advance_pc = 1'b1;
                state_next = FETCH;
            end
            HALTED:  state_next = HALTED;
            default: state_next = FETCH;
        endcase
    end

    // Strobes are masked by reset so a register-file write or ALU launch
    // cannot escape during the cycle that reset is being taken.
    assign bus.alu_start       = start_req && !reset;
    assign bus.wb_en           = wb_req && !reset;
    assign bus.program_counter = pc;
    assign bus.rd_addr_a       = instr_reg[ADDR_A_MSB:ADDR_A_LSB];
    assign bus.rd_addr_b       = instr_reg[ADDR_B_MSB:ADDR_B_LSB];
    assign bus.wb_addr         = instr_reg[ADDR_A_MSB:ADDR_A_LSB];
    assign bus.alu_op          = opcode;

endmodule
